// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the streaming UART blocks (transmitter now, receiver
// later): parity mode encodings, the transmit FSM state type, the bit-period
// calculation and the parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Parity mode encodings, matching the integer PARITY parameter values
   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   // Transmit FSM states, in the order a frame walks through them
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Clock cycles per bit, rounded to the nearest integer
   function automatic int bps_cnt(input int clk_freq, input int baud);
      return (clk_freq + (baud / 32'sd2)) / baud;
   endfunction

   // Parity bit for a payload of up to 9 bits; unused upper bits must be zero
   function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
      logic x;
      x = ^data;
      case (mode)
         PAR_ODD:  return ~x;
         PAR_EVEN: return x;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. Storage is a register array with
// wrap-around pointers (DEPTH must be a power of two); full/empty come from a
// count register one bit wider than the pointers.
//
// Ports:
//   sys_clk  in   clock
//   rst      in   synchronous active-high reset, empties the FIFO
//   wr_en    in   write request (ignored while full)
//   wr_data  in   WIDTH-bit word to write
//   rd_en    in   read request (ignored while empty), advances the head
//   rd_data  out  current head word (valid while not empty)
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored words
// -----------------------------------------------------------------------------
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_wr_s;
   logic             do_rd_s;

   assign do_wr_s = wr_en & ~full;
   assign do_rd_s = rd_en & ~empty;

   assign full    = (count_r == FULL_CNT);
   assign empty   = (count_r == '0);
   assign count   = count_r;
   assign rd_data = mem_r[rd_ptr_r];

   // Storage write; contents need no reset because the count gates every read
   always_ff @(posedge sys_clk) begin
      if (do_wr_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy tracking; simultaneous read and write keep the count
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (do_rd_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
            2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// Streaming UART transmitter. Words arrive on a valid/ready port into an
// internal FIFO and are sent as back-to-back frames: start bit, DATA_BITS
// payload bits LSB first, optional parity bit, STOP_BITS stop bits. Every bit
// lasts BPS_CNT clock cycles.
//
// Ports:
//   sys_clk     in   clock
//   rst         in   synchronous active-high reset (drops queued and in-flight words)
//   s_valid     in   input word valid
//   s_ready     out  FIFO not full (derived from the registered count only)
//   s_data      in   DATA_BITS-bit input word
//   uart_txd    out  serial line, idles high (registered)
//   tx_busy     out  FSM outside IDLE, aligned with the line (registered)
//   frame_done  out  one-cycle pulse on the last cycle of the final stop bit (registered)
//   fifo_count  out  words waiting in the FIFO, excluding the one being sent
// -----------------------------------------------------------------------------
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 1,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_BITS-1:0]          s_data,
   output logic                          uart_txd,
   output logic                          tx_busy,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BPS_CNT = bps_cnt(CLK_FREQ, BAUD);
   localparam int CNT_W   = $clog2(BPS_CNT);
   localparam int IDX_W   = 4;
   localparam int FC_W    = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic [1:0]       PAR_MODE  = 2'(PARITY);

   // FIFO interface
   logic                  push_s;
   logic                  pop_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [DATA_BITS-1:0]  fifo_rd_data_s;
   logic [FC_W-1:0]       fifo_count_s;

   // FSM and datapath
   tx_state_t             state_r;
   tx_state_t             state_next_s;
   logic [CNT_W-1:0]      bit_cnt_r;
   logic [IDX_W-1:0]      bit_idx_r;
   logic [DATA_BITS-1:0]  data_r;
   logic [15:0]           data_ext_s;
   logic                  bit_end_s;
   logic                  data_last_s;
   logic                  stop_last_s;

   // Output stage
   logic                  txd_next_s;
   logic                  busy_next_s;
   logic                  done_next_s;
   logic                  txd_r;
   logic                  busy_r;
   logic                  done_r;

   assign push_s     = s_valid & ~fifo_full_s;
   assign s_ready    = ~fifo_full_s;
   assign fifo_count = fifo_count_s;

   assign uart_txd   = txd_r;
   assign tx_busy    = busy_r;
   assign frame_done = done_r;

   // Widened copy so the 4-bit bit index always addresses a valid bit
   assign data_ext_s  = 16'(data_r);

   assign bit_end_s   = (bit_cnt_r == BIT_LAST);
   assign data_last_s = (state_r == ST_DATA) && bit_end_s && (bit_idx_r == DATA_LAST);
   assign stop_last_s = (state_r == ST_STOP) && bit_end_s && (bit_idx_r == STOP_LAST);

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk (sys_clk),
      .rst     (rst),
      .wr_en   (push_s),
      .wr_data (s_data),
      .rd_en   (pop_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   // FSM state register
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and pop decision; the end of STOP chains straight into START
   // when another word is waiting so frames abut without an idle cycle
   always_comb begin
      state_next_s = state_r;
      pop_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               state_next_s = ST_START;
               pop_s        = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_START;
            end
         end
         ST_DATA: begin
            if (data_last_s) begin
               state_next_s = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_end_s) begin
               state_next_s = ST_STOP;
            end else begin
               state_next_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (stop_last_s) begin
               if (!fifo_empty_s) begin
                  state_next_s = ST_START;
                  pop_s        = 1'b1;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_STOP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Bit-period counter, per-state bit index and the word being shifted out
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         bit_cnt_r <= '0;
         bit_idx_r <= '0;
         data_r    <= '0;
      end else begin
         if (state_r == ST_IDLE) begin
            bit_cnt_r <= '0;
         end else if (bit_end_s) begin
            bit_cnt_r <= '0;
         end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
         end

         // Restart the index on every state change, including STOP -> START
         if (state_next_s != state_r) begin
            bit_idx_r <= '0;
         end else if (bit_end_s) begin
            bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
         end

         if (pop_s) begin
            data_r <= fifo_rd_data_s;
         end
      end
   end

   // Output decode from the current state; registered one cycle later, so the
   // line, busy flag and done pulse all share the same one-cycle lag
   always_comb begin
      txd_next_s  = 1'b1;
      busy_next_s = (state_r != ST_IDLE);
      done_next_s = stop_last_s;
      case (state_r)
         ST_IDLE:   txd_next_s = 1'b1;
         ST_START:  txd_next_s = 1'b0;
         ST_DATA:   txd_next_s = data_ext_s[bit_idx_r];
         ST_PARITY: txd_next_s = parity_bit(9'(data_r), PAR_MODE);
         ST_STOP:   txd_next_s = 1'b1;
         default:   txd_next_s = 1'b1;
      endcase
   end

   // Registered outputs
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         txd_r  <= 1'b1;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         txd_r  <= txd_next_s;
         busy_r <= busy_next_s;
         done_r <= done_next_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
// Three transmitter instances (8O1, 8E1, 7N2) at BPS_CNT = 10. Line, busy and
// done are recorded every cycle; frames are checked against hand-computed bit
// patterns (table) or a small frame-building model (burst).
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

   localparam int CLKF = 1_000_000;
   localparam int BRATE = 100_000;
   localparam int BPS  = 10;
   localparam int CAPN = 8192;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic [2:0] s_valid_v;
   logic [7:0] s_data_v [3];
   logic [2:0] s_ready_v;
   logic [2:0] txd_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [4:0] cnt_v [3];

   logic [2:0] cap_txd  [CAPN];
   logic [2:0] cap_busy [CAPN];
   logic [2:0] cap_done [CAPN];

   int cyc;
   int total;
   int bad;

   always #5 sys_clk = ~sys_clk;

   uart_tx_stream #(.CLK_FREQ(CLKF), .BAUD(BRATE), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
      .sys_clk(sys_clk), .rst(rst), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
      .s_data(s_data_v[0]), .uart_txd(txd_v[0]), .tx_busy(busy_v[0]),
      .frame_done(done_v[0]), .fifo_count(cnt_v[0]));

   uart_tx_stream #(.CLK_FREQ(CLKF), .BAUD(BRATE), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
      .sys_clk(sys_clk), .rst(rst), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
      .s_data(s_data_v[1]), .uart_txd(txd_v[1]), .tx_busy(busy_v[1]),
      .frame_done(done_v[1]), .fifo_count(cnt_v[1]));

   uart_tx_stream #(.CLK_FREQ(CLKF), .BAUD(BRATE), .DATA_BITS(7), .PARITY(0),
                    .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
      .sys_clk(sys_clk), .rst(rst), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]),
      .s_data(s_data_v[2][6:0]), .uart_txd(txd_v[2]), .tx_busy(busy_v[2]),
      .frame_done(done_v[2]), .fifo_count(cnt_v[2]));

   typedef struct {
      int         u;
      logic [7:0] d;
      logic [11:0] bits;   // frame bits, bit 0 = start bit
      int         nb;
   } vec_t;

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
      if (cyc < CAPN) begin
         cap_txd[cyc]  = txd_v;
         cap_busy[cyc] = busy_v;
         cap_done[cyc] = done_v;
      end
   endtask

   task automatic run_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Push one word; returns the cycle index right after the accepting edge
   task automatic push(input int u, input logic [7:0] d, output int t_acc);
      s_valid_v[u] = 1'b1;
      s_data_v[u]  = d;
      check($sformatf("rdy_u%0d", u), 32'(s_ready_v[u]), 32'd1);
      tick();
      s_valid_v[u] = 1'b0;
      t_acc = cyc;
   endtask

   // Independent frame model: start 0, payload LSB first, parity from a 1s count
   function automatic logic [11:0] mk_frame(input logic [7:0] d, input int nbits, input int par);
      logic [11:0] f;
      int ones;
      f = 12'hFFF;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < nbits; i++) begin
         f[1 + i] = d[i];
         if (d[i]) ones++;
      end
      if (par == 1) f[1 + nbits] = ((ones % 2) == 0);
      if (par == 2) f[1 + nbits] = ((ones % 2) == 1);
      return f;
   endfunction

   // Check a recorded frame whose start bit appears on the line at cycle t0
   task automatic check_frame(input int u, input int t0, input logic [11:0] bits,
                              input int nb, input string name);
      int errb, errd, errbz, idx;
      errb = 0; errd = 0; errbz = 0;
      for (int k = 0; k < nb; k++) begin
         for (int c = 0; c < BPS; c++) begin
            idx = t0 + k * BPS + c;
            if (idx >= CAPN) begin
               errb++;
            end else begin
               if (cap_txd[idx][u] !== bits[k]) errb++;
               if (cap_done[idx][u] !== ((k == nb - 1) && (c == BPS - 1))) errd++;
               if (cap_busy[idx][u] !== 1'b1) errbz++;
            end
         end
      end
      check({name, "_bits"}, 32'(errb), 32'd0);
      check({name, "_done"}, 32'(errd), 32'd0);
      check({name, "_busy"}, 32'(errbz), 32'd0);
   endtask

   initial begin
      vec_t vt[10];
      int   t, t0, nacc, first_acc, guard, zeros, dones;
      bit   stop;

      vt[0] = '{0, 8'h55, 12'h6AA, 11};
      vt[1] = '{0, 8'h07, 12'h40E, 11};
      vt[2] = '{1, 8'h07, 12'h60E, 11};
      vt[3] = '{2, 8'h41, 12'h382, 10};
      vt[4] = '{0, 8'h00, 12'h600, 11};
      vt[5] = '{0, 8'hFF, 12'h7FE, 11};
      vt[6] = '{1, 8'hFF, 12'h5FE, 11};
      vt[7] = '{1, 8'h00, 12'h400, 11};
      vt[8] = '{2, 8'h7F, 12'h3FE, 10};
      vt[9] = '{2, 8'h2A, 12'h354, 10};

      cyc = 0; total = 0; bad = 0;
      rst = 1'b1;
      s_valid_v = 3'b000;
      for (int i = 0; i < 3; i++) s_data_v[i] = 8'h00;

      // Power-up reset held 3 cycles
      repeat (3) tick();
      rst = 1'b0;
      check("rst_txd",  32'(txd_v),     32'h7);
      check("rst_rdy",  32'(s_ready_v), 32'h7);
      check("rst_busy", 32'(busy_v),    32'h0);
      check("rst_done", 32'(done_v),    32'h0);
      check("rst_cnt",  32'(cnt_v[0]),  32'h0);

      // Reset while a frame is on the line
      push(0, 8'hA5, t);
      run_until(t + 30);
      rst = 1'b1;
      tick();
      check("mrst_txd",  32'(txd_v[0]),     32'd1);
      check("mrst_busy", 32'(busy_v[0]),    32'd0);
      check("mrst_done", 32'(done_v[0]),    32'd0);
      check("mrst_rdy",  32'(s_ready_v[0]), 32'd1);
      check("mrst_cnt",  32'(cnt_v[0]),     32'd0);
      repeat (2) tick();
      rst = 1'b0;
      t = cyc;
      run_until(t + 200);
      zeros = 0;
      for (int i = t + 1; i <= t + 200; i++) if (cap_txd[i][0] !== 1'b1) zeros++;
      check("mrst_quiet", 32'(zeros), 32'd0);

      // Table of single frames
      for (int i = 0; i < 10; i++) begin
         push(vt[i].u, vt[i].d, t);
         t0 = t + 2;
         run_until(t0 + vt[i].nb * BPS + 2);
         check($sformatf("v%0d_lat", i), 32'(cap_txd[t0 - 1][vt[i].u]), 32'd1);
         check_frame(vt[i].u, t0, vt[i].bits, vt[i].nb, $sformatf("v%0d", i));
         check($sformatf("v%0d_idle", i), 32'(cap_txd[t0 + vt[i].nb * BPS][vt[i].u]), 32'd1);
         check($sformatf("v%0d_ibusy", i), 32'(cap_busy[t0 + vt[i].nb * BPS][vt[i].u]), 32'd0);
      end

      // Burst with s_valid held high until the FIFO fills
      nacc = 0; first_acc = -1; guard = 0; stop = 1'b0;
      while (!stop && guard < 64) begin
         guard++;
         s_valid_v[0] = 1'b1;
         s_data_v[0]  = 8'h30 + 8'(nacc);
         if (s_ready_v[0]) begin
            tick();
            nacc++;
            if (first_acc < 0) first_acc = cyc;
         end else begin
            check("full_cnt", 32'(cnt_v[0]), 32'd16);
            stop = 1'b1;
         end
      end
      s_valid_v[0] = 1'b0;
      check("burst_acc", 32'(nacc), 32'd17);
      run_until(first_acc + 2 + 17 * 110 + 5);
      for (int f = 0; f < 17; f++) begin
         check_frame(0, first_acc + 2 + f * 110, mk_frame(8'h30 + 8'(f), 8, 1), 11,
                     $sformatf("b%0d", f));
      end
      dones = 0;
      for (int i = first_acc; i <= cyc; i++) if (cap_done[i][0] === 1'b1) dones++;
      check("burst_dones", 32'(dones), 32'd17);

      // Reset during DATA bit 3 with 5 words queued
      for (int i = 0; i < 6; i++) begin
         push(0, 8'hC0 + 8'(i), t);
         if (i == 0) t0 = t + 2;
      end
      check("q5_cnt", 32'(cnt_v[0]), 32'd5);
      run_until(t0 + 4 * BPS + 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("dr_txd",  32'(txd_v[0]),  32'd1);
      check("dr_cnt",  32'(cnt_v[0]),  32'd0);
      check("dr_busy", 32'(busy_v[0]), 32'd0);
      t = cyc;
      run_until(t + 300);
      zeros = 0; dones = 0;
      for (int i = t + 1; i <= t + 300; i++) begin
         if (cap_txd[i][0] !== 1'b1) zeros++;
         if (cap_done[i][0] === 1'b1) dones++;
      end
      check("dr_quiet", 32'(zeros), 32'd0);
      check("dr_nodone", 32'(dones), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
